// File: rtl/ps2_pkg.sv
// Shared constants and FSM state type for the PS/2 keyboard control path.
// Scancode values are PS/2 set 2.
package ps2_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  typedef enum logic {
    IDLE,
    DECODE
  } state_t;

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational set-2 scancode to lowercase ASCII lookup: letters, digits,
// space and enter; every other code maps to ASCII_NONE.
module ps2_scan2ascii #(
  parameter logic [7:0] ASCII_NONE = 8'h00
) (
  input  logic [7:0] scan,
  output logic [7:0] ascii
);

  always_comb begin
    // NOTE: the default assignment first keeps unlisted codes from inferring a latch.
    ascii = ASCII_NONE;
    case (scan)
      8'h1C: ascii = 8'h61; 8'h32: ascii = 8'h62; 8'h21: ascii = 8'h63;
      8'h23: ascii = 8'h64; 8'h24: ascii = 8'h65; 8'h2B: ascii = 8'h66;
      8'h34: ascii = 8'h67; 8'h33: ascii = 8'h68; 8'h43: ascii = 8'h69;
      8'h3B: ascii = 8'h6A; 8'h42: ascii = 8'h6B; 8'h4B: ascii = 8'h6C;
      8'h3A: ascii = 8'h6D; 8'h31: ascii = 8'h6E; 8'h44: ascii = 8'h6F;
      8'h4D: ascii = 8'h70; 8'h15: ascii = 8'h71; 8'h2D: ascii = 8'h72;
      8'h1B: ascii = 8'h73; 8'h2C: ascii = 8'h74; 8'h3C: ascii = 8'h75;
      8'h2A: ascii = 8'h76; 8'h1D: ascii = 8'h77; 8'h22: ascii = 8'h78;
      8'h35: ascii = 8'h79; 8'h1A: ascii = 8'h7A;
      8'h45: ascii = 8'h30; 8'h16: ascii = 8'h31; 8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33; 8'h25: ascii = 8'h34; 8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36; 8'h3D: ascii = 8'h37; 8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h29: ascii = 8'h20;
      8'h5A: ascii = 8'h0D;
      default: ascii = ASCII_NONE;
    endcase
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// Pops PS/2 scancodes from the receiver FIFO, decodes make/break/extended
// sequences and drives the display. Define PS2_SHIFT_CASE_EN for shift-aware case.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter logic [23:0] TMO_CYCLES = 24'd5_000_000,
  parameter logic [7:0]  ASCII_NONE = 8'h00
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] kb_data,
  input  logic       kb_ready,
  input  logic       kb_overflow,
  output logic       kb_nextdata_n,
  output logic [7:0] key_num,
  output logic [7:0] asc_num,
  output logic [7:0] key_times,
  output logic       seg_blank,
  output logic       ovf_sticky
);

  state_t      state;
  logic [7:0]  byte_q;
  logic        brk;
  logic        ext;
  logic        held;
  logic [8:0]  held_code;
  logic [23:0] tmo_cnt;
  logic [7:0]  rom_asc;
  logic [7:0]  asc_next;
`ifdef PS2_SHIFT_CASE_EN
  logic        shift_l;
  logic        shift_r;
`endif

  ps2_scan2ascii #(.ASCII_NONE(ASCII_NONE)) u_scan2ascii (
    .scan  (byte_q),
    .ascii (rom_asc)
  );

  always_comb begin
    asc_next = ext ? ASCII_NONE : rom_asc;
`ifdef PS2_SHIFT_CASE_EN
    if (!ext && (shift_l || shift_r) && rom_asc >= 8'h61 && rom_asc <= 8'h7A)
      asc_next = rom_asc - 8'h20;
`endif
  end

  // NOTE: sequential state uses <= only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state         <= IDLE;
      byte_q        <= 8'h00;
      kb_nextdata_n <= 1'b1;
      key_num       <= 8'h00;
      asc_num       <= 8'h00;
      key_times     <= 8'h00;
      seg_blank     <= 1'b1;
      ovf_sticky    <= 1'b0;
      brk           <= 1'b0;
      ext           <= 1'b0;
      held          <= 1'b0;
      held_code     <= 9'h000;
      tmo_cnt       <= 24'd0;
`ifdef PS2_SHIFT_CASE_EN
      shift_l       <= 1'b0;
      shift_r       <= 1'b0;
`endif
    end else begin
      if (kb_overflow) ovf_sticky <= 1'b1;

      case (state)
        IDLE: begin
          if (kb_ready) begin
            byte_q        <= kb_data;
            kb_nextdata_n <= 1'b0;
            tmo_cnt       <= 24'd0;
            state         <= DECODE;
          end else if (brk || ext) begin
            // A dangling prefix is dropped so a lost byte cannot poison the next key.
            if (tmo_cnt == TMO_CYCLES - 24'd1) begin
              brk     <= 1'b0;
              ext     <= 1'b0;
              tmo_cnt <= 24'd0;
            end else begin
              tmo_cnt <= tmo_cnt + 24'd1;
            end
          end
        end

        DECODE: begin
          kb_nextdata_n <= 1'b1;
          state         <= IDLE;
          if (byte_q == SC_EXT) begin
            ext <= 1'b1;
          end else if (byte_q == SC_BRK) begin
            brk <= 1'b1;
`ifdef PS2_SHIFT_CASE_EN
          end else if (!ext && (byte_q == SC_LSHIFT || byte_q == SC_RSHIFT)) begin
            if (byte_q == SC_LSHIFT) shift_l <= !brk;
            else                     shift_r <= !brk;
            brk <= 1'b0;
            ext <= 1'b0;
`endif
          end else if (brk) begin
            // Only releasing the last-pressed key blanks the display.
            if ({ext, byte_q} == held_code) begin
              held      <= 1'b0;
              seg_blank <= 1'b1;
            end
            brk <= 1'b0;
            ext <= 1'b0;
          end else if (held && {ext, byte_q} == held_code) begin
            ext <= 1'b0;
          end else begin
            key_num   <= byte_q;
            asc_num   <= asc_next;
            key_times <= key_times + 8'd1;
            held      <= 1'b1;
            held_code <= {ext, byte_q};
            seg_blank <= 1'b0;
            ext       <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Randomized self-checking bench for ps2_key_ctrl against a byte-stream
// reference model; honours PS2_SHIFT_CASE_EN when defined.
module tb_ps2_key_ctrl;

  localparam logic [23:0] TMO = 24'd16;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] kb_data = 8'h00;
  logic       kb_ready = 1'b0;
  logic       kb_overflow = 1'b0;
  logic       kb_nextdata_n;
  logic [7:0] key_num, asc_num, key_times;
  logic       seg_blank, ovf_sticky;

  always #5 clk = ~clk;

  ps2_key_ctrl #(.TMO_CYCLES(TMO), .ASCII_NONE(8'h00)) dut (
    .clk           (clk),
    .clrn          (clrn),
    .kb_data       (kb_data),
    .kb_ready      (kb_ready),
    .kb_overflow   (kb_overflow),
    .kb_nextdata_n (kb_nextdata_n),
    .key_num       (key_num),
    .asc_num       (asc_num),
    .key_times     (key_times),
    .seg_blank     (seg_blank),
    .ovf_sticky    (ovf_sticky)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO model: a pop happens on each falling edge of kb_nextdata_n.
  logic [7:0] fifo[$];
  int pops = 0;
  int bad_pops = 0;
  int wide_pulses = 0;
  logic prev_nd = 1'b1;

  task automatic drive_fifo();
    kb_ready = (fifo.size() != 0);
    kb_data  = kb_ready ? fifo[0] : 8'h00;
  endtask

  always @(negedge kb_nextdata_n) begin
    if (clrn) begin
      if (fifo.size() == 0) bad_pops++;
      else begin
        void'(fifo.pop_front());
        pops++;
      end
      drive_fifo();
    end
  end

  always @(negedge clk) begin
    if (!kb_nextdata_n && !prev_nd) wide_pulses++;
    prev_nd = kb_nextdata_n;
  end

  // Reference model: key-level behaviour of the decoder.
  logic [7:0] asc_tab [256];
  bit         m_brk, m_ext, m_held, m_shl, m_shr, m_blank;
  logic [8:0] m_code;
  logic [7:0] m_key, m_asc, m_times;

  function automatic void model_reset();
    m_brk = 0; m_ext = 0; m_held = 0; m_shl = 0; m_shr = 0; m_blank = 1;
    m_code = '0; m_key = '0; m_asc = '0; m_times = '0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    logic [7:0] a;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
`ifdef PS2_SHIFT_CASE_EN
    else if (!m_ext && (b == 8'h12 || b == 8'h59)) begin
      if (b == 8'h12) m_shl = !m_brk; else m_shr = !m_brk;
      m_brk = 0; m_ext = 0;
    end
`endif
    else if (m_brk) begin
      if (m_held && {m_ext, b} == m_code) begin m_held = 0; m_blank = 1; end
      m_brk = 0; m_ext = 0;
    end else if (m_held && {m_ext, b} == m_code) begin
      m_ext = 0;
    end else begin
      a = m_ext ? 8'h00 : asc_tab[b];
      if ((m_shl || m_shr) && a >= "a" && a <= "z") a = a - 8'd32;
      m_key = b; m_asc = a; m_times = m_times + 8'd1;
      m_held = 1; m_code = {m_ext, b}; m_blank = 0; m_ext = 0;
    end
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".key_num"},   key_num,   m_key);
    check({tag, ".asc_num"},   asc_num,   m_asc);
    check({tag, ".key_times"}, key_times, m_times);
    check({tag, ".seg_blank"}, seg_blank, m_blank);
  endtask

  // Push one byte, wait for its pop, check outputs two edges after sampling,
  // then idle; a gap of 20+ cycles outlasts the prefix timeout.
  task automatic send_byte(input logic [7:0] b, input int gap, input string tag);
    int p0, n;
    @(negedge clk);
    fifo.push_back(b);
    drive_fifo();
    p0 = pops;
    n = 0;
    while (pops == p0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".pop"}, pops - p0, 1);
    @(negedge clk);
    model_byte(b);
    check_outputs(tag);
    repeat (gap) @(negedge clk);
    if (gap >= 20) begin m_brk = 0; m_ext = 0; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clrn = 1'b0;
    fifo.delete();
    drive_fifo();
    model_reset();
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
  endtask

  localparam logic [7:0] LET_SC [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B,
    8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIG_SC [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
    8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] POOL [10] = '{8'h1C, 8'h32, 8'h21, 8'h75, 8'h29, 8'h5A, 8'h45,
    8'h16, 8'h12, 8'h59};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] t0, b;
    int r, gap, p0;

    for (int i = 0; i < 256; i++) asc_tab[i] = 8'h00;
    for (int i = 0; i < 26; i++) asc_tab[LET_SC[i]] = 8'h61 + 8'(i);
    for (int i = 0; i < 10; i++) asc_tab[DIG_SC[i]] = 8'h30 + 8'(i);
    asc_tab[8'h29] = 8'h20;
    asc_tab[8'h5A] = 8'h0D;
    model_reset();

    repeat (3) @(negedge clk);
    check("rst.nextdata_n", kb_nextdata_n, 1);
    check("rst.ovf_sticky", ovf_sticky, 0);
    check_outputs("rst");
    clrn = 1'b1;
    @(negedge clk);

    // Single make
    send_byte(8'h1C, 2, "make1C");
    check("make1C.asc", asc_num, 8'h61);
    check("make1C.times", key_times, 8'h01);

    // Typematic repeats, then release
    send_byte(8'h1C, 1, "rep1");
    send_byte(8'h1C, 0, "rep2");
    send_byte(8'h1C, 3, "rep3");
    send_byte(8'hF0, 1, "brk");
    send_byte(8'h1C, 1, "rel1C");
    check("rel1C.times", key_times, 8'h01);
    check("rel1C.blank", seg_blank, 1);
    check("rel1C.key", key_num, 8'h1C);

    // Extended key; plain break must not release it
    send_byte(8'hE0, 0, "ext");
    send_byte(8'h75, 0, "ext75");
    check("ext75.asc", asc_num, 8'h00);
    check("ext75.times", key_times, 8'h02);
    send_byte(8'hF0, 0, "pbrk");
    send_byte(8'h75, 0, "prel75");
    check("prel75.blank", seg_blank, 0);
    send_byte(8'hE0, 0, "ebrk0");
    send_byte(8'hF0, 0, "ebrk1");
    send_byte(8'h75, 0, "erel75");
    check("erel75.blank", seg_blank, 1);

    // Prefix timeout: a stale F0 must be dropped
    t0 = m_times;
    send_byte(8'hF0, 30, "tmo.f0");
    send_byte(8'h1C, 2, "tmo.1C");
    check("tmo.times", key_times, t0 + 8'd1);
    send_byte(8'hF0, 2, "ntmo.f0");
    send_byte(8'h1C, 2, "ntmo.1C");
    check("ntmo.blank", seg_blank, 1);

    // Overflow sticky flag
    @(negedge clk);
    kb_overflow = 1'b1;
    @(negedge clk);
    kb_overflow = 1'b0;
    check("ovf.set", ovf_sticky, 1);

    // 256 make/break pairs wrap the press counter
    t0 = m_times;
    for (int i = 0; i < 256; i++) begin
      b = LET_SC[i % 26];
      send_byte(b, 0, "wrap.mk");
      send_byte(8'hF0, 0, "wrap.f0");
      send_byte(b, 0, "wrap.rl");
    end
    check("wrap.times", key_times, t0);
    check("ovf.hold", ovf_sticky, 1);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 12)      b = 8'hE0;
      else if (r < 25) b = 8'hF0;
      else             b = POOL[$urandom_range(0, 9)];
      gap = ($urandom_range(0, 9) == 0) ? 30 : $urandom_range(0, 3);
      send_byte(b, gap, "rand");
    end

    // Reset asserted in the middle of DECODE
    @(negedge clk);
    fifo.push_back(8'h1C);
    drive_fifo();
    p0 = pops;
    @(posedge clk);
    #2;
    check("rstdec.in_decode", kb_nextdata_n, 0);
    clrn = 1'b0;
    #1;
    model_reset();
    check("rstdec.nextdata_n", kb_nextdata_n, 1);
    check("rstdec.popped", pops - p0, 1);
    check("rstdec.ovf", ovf_sticky, 0);
    check_outputs("rstdec");
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    repeat (6) @(negedge clk);
    check("rstdec.no_reread", pops - p0, 1);
    check_outputs("rstdec.after");

    // Shift handling (ordinary keys when the feature is off)
    send_byte(8'h12, 1, "sh.12");
    send_byte(8'h1C, 1, "sh.1C");
`ifdef PS2_SHIFT_CASE_EN
    check("sh.asc", asc_num, 8'h41);
    check("sh.times", key_times, 8'h01);
    send_byte(8'hF0, 0, "sh.f0");
    send_byte(8'h12, 0, "sh.rel");
    send_byte(8'h32, 1, "sh.32");
    check("sh.lower", asc_num, 8'h62);
`else
    check("sh.asc", asc_num, 8'h61);
    check("sh.times", key_times, 8'h02);
`endif

    repeat (4) @(negedge clk);
    check("pop_while_empty", bad_pops, 0);
    check("pop_pulse_width", wide_pulses, 0);
    check("fifo_drained", fifo.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
